// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared types for the MD particle pipeline.
//   PARTICLE_ID_WIDTH : width of particle ids, cache addresses and counts
//   particle_id_t     : unsigned particle id / count
//   bcast_state_t     : home broadcast controller states
//   bcast_tag_t       : side-band tag travelling alongside a cache read
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int PARTICLE_ID_WIDTH = 8;

    typedef logic [PARTICLE_ID_WIDTH-1:0] particle_id_t;

    typedef enum logic [2:0] {
        IDLE,
        CNT_WAIT,
        SWEEP,
        DRAIN,
        FINISH
    } bcast_state_t;

    // ref_id carries the reference particle id ("ref" is a reserved word).
    typedef struct packed {
        logic         valid;
        particle_id_t id;
        particle_id_t ref_id;
        logic         phase;
    } bcast_tag_t;

endpackage

// File: rtl/home_bcast_ctrl_tag_delay.sv
// -----------------------------------------------------------------------------
// bcast_tag_delay
// RD_LATENCY-deep shift register of bcast_tag_t that matches the side-band tag
// to the cache read latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : tag registered alongside rd_en/rd_addr
//   dout       : tag aligned with the returning cache data
// -----------------------------------------------------------------------------
module bcast_tag_delay
    import md_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  bcast_tag_t din,
    output bcast_tag_t dout
);

    bcast_tag_t stage [RD_LATENCY];

    // NOTE: this small array is reset on purpose: its valid bits must never
    // show X beats after reset. A large data memory would not be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[RD_LATENCY-1];

endmodule

// File: rtl/home_bcast_ctrl.sv
// -----------------------------------------------------------------------------
// home_bcast_ctrl
// Sequences the home-cell cache read-out: reads the particle count word at
// address 0, then for each reference particle sweeps all home particles in
// phase 0 and again in phase 1. The side-band tag is delay-matched to the
// cache read latency so it arrives with the data.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a pass (only in IDLE)
//   stall                back-pressure, freezes address issue in SWEEP
//   cnt_data             count-word bits of the cache read data
//   rd_en, rd_addr       cache read request
//   bcast_valid          data on the bus is a particle beat
//   particle_id, ref_id  tag of the beat on the bus (held when not valid)
//   phase, prev_phase    half-shell phase of the beat, and one cycle later
//   reading_particle_num count word is on the bus this cycle
//   busy, done           pass in progress / one-cycle completion pulse
//
// Optional: define HOME_BCAST_PERF_EN to add perf_cycles (busy cycles) and
// perf_stalls (stalled SWEEP cycles), both cleared on start and saturating.
// -----------------------------------------------------------------------------
module home_bcast_ctrl
    import md_pkg::*;
#(
    parameter int RD_LATENCY = 2,               // 1..4
    parameter int ADDR_WIDTH = PARTICLE_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stall,
    input  logic [PARTICLE_ID_WIDTH-1:0] cnt_data,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         bcast_valid,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         phase,
    output logic                         prev_phase,
    output logic                         reading_particle_num,
    output logic                         busy,
    output logic                         done
`ifdef HOME_BCAST_PERF_EN
    ,
    output logic [31:0]                  perf_cycles,
    output logic [31:0]                  perf_stalls
`endif
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    bcast_state_t state;
    particle_id_t n_cnt;
    particle_id_t addr;
    particle_id_t ref_cnt;
    logic         ph;
    logic [2:0]   wait_cnt;
    bcast_tag_t   issue_tag;
    bcast_tag_t   bus_tag;

    // NOTE: all state here updates with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            n_cnt                <= '0;
            addr                 <= '0;
            ref_cnt              <= '0;
            ph                   <= 1'b0;
            wait_cnt             <= '0;
            issue_tag            <= '0;
            rd_en                <= 1'b0;
            rd_addr              <= '0;
            reading_particle_num <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            // Pulse-type outputs; the tag fields keep their last issued value
            // so the delayed side-band holds steady between beats.
            rd_en                <= 1'b0;
            issue_tag.valid      <= 1'b0;
            reading_particle_num <= 1'b0;
            done                 <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= CNT_WAIT;
                    end
                end

                CNT_WAIT: begin
                    // reading_particle_num is high exactly when the count
                    // word is on the bus, so it also marks the latch cycle.
                    if (reading_particle_num) begin
                        n_cnt <= cnt_data;
                        if (cnt_data == '0) begin
                            state <= FINISH;
                        end else begin
                            ref_cnt <= particle_id_t'(1);
                            ph      <= 1'b0;
                            addr    <= particle_id_t'(1);
                            state   <= SWEEP;
                        end
                    end else if (wait_cnt == LAT_LAST) begin
                        reading_particle_num <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                SWEEP: begin
                    if (!stall) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= ADDR_WIDTH'(addr);
                        issue_tag <= bcast_tag_t'{valid: 1'b1, id: addr,
                                                  ref_id: ref_cnt, phase: ph};
                        // Equality wrap keeps arithmetic in range for N=max.
                        if (addr == n_cnt) begin
                            if (ph && (ref_cnt == n_cnt)) begin
                                wait_cnt <= '0;
                                state    <= DRAIN;
                            end else begin
                                addr <= particle_id_t'(1);
                                if (!ph) begin
                                    ph <= 1'b1;
                                end else begin
                                    ph      <= 1'b0;
                                    ref_cnt <= ref_cnt + particle_id_t'(1);
                                end
                            end
                        end else begin
                            addr <= addr + particle_id_t'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (wait_cnt == LAT_LAST) state <= FINISH;
                    else                      wait_cnt <= wait_cnt + 3'd1;
                end

                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // issue_tag is aligned with rd_en; RD_LATENCY more stages align it with
    // the returning data.
    bcast_tag_delay #(.RD_LATENCY(RD_LATENCY)) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (issue_tag),
        .dout  (bus_tag)
    );

    assign bcast_valid = bus_tag.valid;
    assign particle_id = bus_tag.id;
    assign ref_id      = bus_tag.ref_id;
    assign phase       = bus_tag.phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_phase <= 1'b0;
        else        prev_phase <= phase;
    end

`ifdef HOME_BCAST_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if ((state == IDLE) && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 32'd1;
            if ((state == SWEEP) && stall && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_home_bcast_ctrl.sv
// -----------------------------------------------------------------------------
// tb_home_bcast_ctrl
// Directed bench for home_bcast_ctrl with RD_LATENCY=2. A small cache model
// returns the count word at address 0 exactly RD_LATENCY cycles after the
// read, and a filler value for every other address.
// -----------------------------------------------------------------------------
module tb_home_bcast_ctrl;
    import md_pkg::*;

    localparam int L    = 2;
    localparam int MAXC = 400;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stall;
    particle_id_t cnt_data;
    logic         rd_en;
    particle_id_t rd_addr;
    logic         bcast_valid;
    particle_id_t particle_id;
    particle_id_t ref_id;
    logic         phase;
    logic         prev_phase;
    logic         reading_particle_num;
    logic         busy;
    logic         done;
`ifdef HOME_BCAST_PERF_EN
    logic [31:0]  perf_cycles;
    logic [31:0]  perf_stalls;
`endif

    int checks = 0;
    int errors = 0;
    bit exp_hold_phase = 1'b0;   // phase value the side-band is holding

    home_bcast_ctrl #(.RD_LATENCY(L), .ADDR_WIDTH(PARTICLE_ID_WIDTH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .stall                (stall),
        .cnt_data             (cnt_data),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .bcast_valid          (bcast_valid),
        .particle_id          (particle_id),
        .ref_id               (ref_id),
        .phase                (phase),
        .prev_phase           (prev_phase),
        .reading_particle_num (reading_particle_num),
        .busy                 (busy),
        .done                 (done)
`ifdef HOME_BCAST_PERF_EN
        ,
        .perf_cycles          (perf_cycles),
        .perf_stalls          (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One pass. Cycle c counts clock edges after the edge that samples start.
    task automatic run_pass(input int n, input int stall_at, input int stall_len,
                            input int repulse_at, input string name);
        logic         hist_en   [0:MAXC];
        particle_id_t hist_addr [0:MAXC];
        int c, beats, rd_cnt, rpn_cnt, falls, done_cyc, done_cnt, exp_done;
        int busy_err, hold_err, timing_err, stall_rd, frz_err, exp_falls;
        bit prev_pp, last_ph, exp_busy;
        particle_id_t frz_addr, e_id, e_ref;
        bit e_ph;

        beats = 0; rd_cnt = 0; rpn_cnt = 0; falls = 0; done_cyc = -1;
        done_cnt = 0; busy_err = 0; hold_err = 0; timing_err = 0;
        stall_rd = 0; frz_err = 0; frz_addr = '0;
        exp_done  = (n == 0) ? L + 3 : 2*n*n + 2*L + 3 + stall_len;
        exp_falls = (n > 0) ? n - 1 + int'(exp_hold_phase) : 0;
        prev_pp   = exp_hold_phase;
        last_ph   = exp_hold_phase;

        @(negedge clk);
        start    = 1'b1;
        cnt_data = 8'hEE;
        @(posedge clk);
        c = 0;
        while (c < exp_done + 6 && c < MAXC - 1) begin
            @(negedge clk);
            c++;
            start = (c == repulse_at);
            stall = (c >= stall_at) && (c < stall_at + stall_len);
            hist_en[c]   = rd_en;
            hist_addr[c] = rd_addr;
            // Cache model: data for a read in cycle t is on the bus at t+L.
            if (c - L >= 1 && hist_en[c-L])
                cnt_data = (hist_addr[c-L] == 0) ? particle_id_t'(n)
                                                 : 8'h40 + hist_addr[c-L];
            else
                cnt_data = 8'hEE;

            if (rd_en) begin
                rd_cnt++;
                if (rd_cnt == 1) begin
                    checks++;
                    if (rd_addr !== 8'd0) begin
                        errors++;
                        $display("FAIL %s first_rd_addr: got %0d expected 0", name, rd_addr);
                    end
                end
            end
            if (reading_particle_num) begin
                rpn_cnt++;
                checks++;
                if (c != 1 + L) begin
                    errors++;
                    $display("FAIL %s rpn_cycle: got %0d expected %0d", name, c, 1 + L);
                end
            end
            exp_busy = (c < exp_done);
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end

            if (bcast_valid === 1'b1) begin
                if (beats < 2*n*n) begin
                    e_ref = particle_id_t'(1 + beats / (2*n));
                    e_ph  = ((beats / n) % 2) == 1;
                    e_id  = particle_id_t'(1 + beats % n);
                    checks++;
                    if (particle_id !== e_id || ref_id !== e_ref || phase !== e_ph) begin
                        errors++;
                        $display("FAIL %s beat%0d: got id=%0d ref=%0d ph=%0d expected id=%0d ref=%0d ph=%0d",
                                 name, beats, particle_id, ref_id, phase, e_id, e_ref, e_ph);
                    end
                    last_ph = e_ph;
                end
                if (!(c - L >= 1 && hist_en[c-L] && hist_addr[c-L] == particle_id))
                    timing_err++;
                beats++;
            end else if (phase !== last_ph) begin
                hold_err++;
            end
            if (prev_pp && prev_phase === 1'b0) falls++;
            prev_pp = (prev_phase === 1'b1);

            if (stall_len > 0) begin
                if (c == stall_at) frz_addr = rd_addr;
                if (c > stall_at && c <= stall_at + stall_len) begin
                    if (rd_en !== 1'b0) stall_rd++;
                    if (rd_addr !== frz_addr) frz_err++;
                end
            end
        end
        start = 1'b0;
        stall = 1'b0;

        checks++;
        if (beats != 2*n*n) begin
            errors++;
            $display("FAIL %s beat_count: got %0d expected %0d", name, beats, 2*n*n);
        end
        checks++;
        if (rd_cnt != 1 + 2*n*n) begin
            errors++;
            $display("FAIL %s rd_count: got %0d expected %0d", name, rd_cnt, 1 + 2*n*n);
        end
        checks++;
        if (rpn_cnt != 1) begin
            errors++;
            $display("FAIL %s rpn_count: got %0d expected 1", name, rpn_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                     name, done_cnt, done_cyc, exp_done);
        end
        checks++;
        if (falls != exp_falls) begin
            errors++;
            $display("FAIL %s prev_phase_falls: got %0d expected %0d", name, falls, exp_falls);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL %s busy: got %0d bad cycles expected 0", name, busy_err);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL %s side_band_hold: got %0d phase changes expected 0", name, hold_err);
        end
        checks++;
        if (timing_err != 0) begin
            errors++;
            $display("FAIL %s beat_alignment: got %0d misaligned expected 0", name, timing_err);
        end
        if (stall_len > 0) begin
            checks++;
            if (stall_rd != 0 || frz_err != 0) begin
                errors++;
                $display("FAIL %s stall_freeze: got %0d reads %0d addr moves expected 0 0",
                         name, stall_rd, frz_err);
            end
        end
        if (n > 0) exp_hold_phase = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_hold_phase = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rd_en, rd_addr, bcast_valid, particle_id, ref_id, phase, prev_phase,
             reading_particle_num, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%b addr=%0d valid=%b busy=%b done=%b expected all 0",
                     rd_en, rd_addr, bcast_valid, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hold_phase = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b rd_en=%b expected 0 0", busy, rd_en);
        end
    endtask

    task automatic test_empty();
        run_pass(0, -1, 0, -1, "n0");
    endtask

    task automatic test_single();
        run_pass(1, -1, 0, -1, "n1");
    endtask

    task automatic test_sweep();
        pulse_reset();
        run_pass(3, -1, 0, -1, "n3");
    endtask

    task automatic test_stall();
        run_pass(3, 10, 4, -1, "n3_stall");
    endtask

    task automatic test_restart_ignored();
        run_pass(3, -1, 0, 10, "n3_restart");
    endtask

    task automatic test_reset_mid_pass();
        @(negedge clk);
        start    = 1'b1;
        cnt_data = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_addr, bcast_valid, particle_id, ref_id, phase, prev_phase,
             reading_particle_num, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got valid=%b id=%0d ref=%0d ph=%b busy=%b expected all 0",
                     bcast_valid, particle_id, ref_id, phase, busy);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        exp_hold_phase = 1'b0;
        run_pass(5, -1, 0, -1, "n5_after_abort");
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        cnt_data = '0;
        test_reset();
        test_empty();
        test_single();
        test_sweep();
        test_stall();
        test_restart_ignored();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/home_bcast_ctrl.md
Name: home_bcast_ctrl

Overview:
- Sequences the home-cell particle cache read-out that feeds the per-neighbour reference-data extractors.
- Reads the particle count word, then steps through every reference particle of the home cell. For each reference particle it sweeps every home particle twice: phase 0, then phase 1.
- Drives the cache read address and the broadcast side-band: particle_id, ref_id, phase, prev_phase, reading_particle_num. The side-band is delay-matched to the cache read latency, so it arrives cycle-aligned with the data.
- Sits between the top-level step sequencer and the home cell cache plus extractor bank.

Parameters:
RD_LATENCY, 2, cache read latency in cycles (allowed range 1..4)
ADDR_WIDTH, PARTICLE_ID_WIDTH, cache address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a cell pass (ignored unless IDLE)
stall  in  1  downstream back-pressure; freezes address issue
cnt_data  in  PARTICLE_ID_WIDTH  cache read data bits [PARTICLE_ID_WIDTH-1:0] of offset_x
rd_en  out  1  cache read enable
rd_addr  out  ADDR_WIDTH  cache read address
bcast_valid  out  1  cache data on the bus is a valid particle beat
particle_id  out  PARTICLE_ID_WIDTH  id of the particle on the bus
ref_id  out  PARTICLE_ID_WIDTH  current reference particle id
phase  out  1  half-shell phase of the beat
prev_phase  out  1  phase output registered one cycle
reading_particle_num  out  1  count word is on the bus this cycle
busy  out  1  pass in progress
done  out  1  one-cycle pulse when the pass completes

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; state IDLE; counters 0. Reset mid-pass aborts immediately; no done pulse is produced.
- State IDLE: on start, issue rd_en=1, rd_addr=0 and go to CNT_WAIT. busy=1 from the cycle after start.
- State CNT_WAIT: wait RD_LATENCY cycles. reading_particle_num=1 in the cycle the count word returns; cnt_data is latched as N that cycle.
  - N==0: go to FINISH.
  - Otherwise: ref=1, ph=0, addr=1, go to SWEEP.
- State SWEEP: each cycle with stall==0, issue rd_en=1, rd_addr=addr, tagged (id=addr, ref, ph).
  - addr increments until addr==N.
  - At addr==N: addr wraps to 1. If ph==0, set ph=1. Else set ph=0 and ref+1.
  - If ref==N and ph==1 when addr==N: go to DRAIN instead.
  - stall==1: rd_en=0, counters hold. Reads already issued still return and remain valid.
- State DRAIN: wait RD_LATENCY cycles for in-flight beats, then go to FINISH.
- State FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Side-band pipeline:
  - The tag (valid, id, ref, ph) enters a RD_LATENCY-deep shift register; its output drives bcast_valid, particle_id, ref_id, phase.
  - Outputs hold their last value when bcast_valid==0, so the extractor never sees a spurious phase edge.
  - prev_phase <= phase every cycle.
  - A 1->0 phase transition at the output marks completion of one reference particle.
- Address/count arithmetic is PARTICLE_ID_WIDTH unsigned. N is at most 2^PARTICLE_ID_WIDTH-1, so no overflow at addr==N. The wrap check uses equality, never addr+1.
- Total issued beats = 2*N*N. Pass latency without stall = 2*N*N + 2*RD_LATENCY + 3 cycles from start to done.
- start while busy is ignored. stall in IDLE/CNT_WAIT/DRAIN has no effect.

Optional Feature:
- HOME_BCAST_PERF_EN defined: adds two 32-bit outputs.
  - perf_cycles: cycles with busy==1.
  - perf_stalls: SWEEP cycles with stall==1.
  - Both clear on start and saturate at 2^32-1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Add to md_pkg:
  - typedef bcast_state_t (IDLE, CNT_WAIT, SWEEP, DRAIN, FINISH).
  - typedef bcast_tag_t {valid, particle_id_t id, particle_id_t ref, phase}.
- Reuse particle_id_t and PARTICLE_ID_WIDTH from md_pkg.
- One sub-module: bcast_tag_delay (parameterised RD_LATENCY shift register of bcast_tag_t with async active-low reset).

Test Plan:
- N=0, RD_LATENCY=2: start -> one rd_en at addr 0, reading_particle_num at cycle 3, done pulse, zero bcast_valid beats.
- N=1: beats are (id1,ref1,ph0),(id1,ref1,ph1); done; total 2 valid beats.
- N=3, no stall: 18 valid beats in order ref1 ph0 ids1-3, ref1 ph1 ids1-3, ref2 ph0 ...; prev_phase 1->0 exactly twice; done at cycle 2*9+7=25 after start.
- N=3, stall asserted 4 cycles mid-sweep: rd_addr frozen; beat sequence identical to the no-stall case; done delayed by 4 cycles.
- rst_n low during SWEEP with N=5: all outputs 0 asynchronously; no done; a new start performs a full clean pass.
- start re-pulsed while busy: no change to beat sequence or done timing.
